// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: field positions, fetch
// states, buffer entry layout and the default reset vector.
package inst_fetch_pkg;

  localparam int unsigned OP_MSB   = 31;
  localparam int unsigned OP_LSB   = 26;
  localparam int unsigned FUNC_MSB = 5;
  localparam int unsigned FUNC_LSB = 0;

  localparam int unsigned OP_W   = OP_MSB - OP_LSB + 1;
  localparam int unsigned FUNC_W = FUNC_MSB - FUNC_LSB + 1;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned FIFO_ENTRIES     = 2;

  typedef enum logic [0:0] {
    FETCH_ST_FETCH = 1'b0,
    FETCH_ST_DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: imem request/ack, redirect input and instruction output.
// fetch_misalign_err exists only when INST_FETCH_MISALIGN_CHK_EN is defined.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic              imem_req;
  logic [31:0]       imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  logic              redirect_valid;
  logic [31:0]       redirect_pc;

  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst_word;
  logic [31:0]       inst_pc;
  logic [OP_W-1:0]   inst_op;
  logic [FUNC_W-1:0] inst_func;

`ifdef INST_FETCH_MISALIGN_CHK_EN
  logic              fetch_misalign_err;
`endif

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_word, inst_pc, inst_op, inst_func,
    input  inst_ready
`ifdef INST_FETCH_MISALIGN_CHK_EN
    , output fetch_misalign_err
`endif
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_word, inst_pc, inst_op, inst_func,
    output inst_ready
`ifdef INST_FETCH_MISALIGN_CHK_EN
    , input fetch_misalign_err
`endif
  );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Two-entry synchronous FIFO with flush. entry0 is always the head, so the
// head register only moves on pop, push-into-empty, or pop+push at one entry.
module inst_fetch_fifo #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;
  logic             push_ok;
  logic             pop_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && (count != 2'd2);
  assign head    = entry0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      entry0 <= '0;
      entry1 <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (pop_ok) begin
        // With one entry and no push the head keeps its last value.
        if (count == 2'd2) begin
          entry0 <= entry1;
        end else if (push_ok) begin
          entry0 <= push_data;
        end
      end else if (push_ok) begin
        if (count == 2'd0) begin
          entry0 <= push_data;
        end else begin
          entry1 <= push_data;
        end
      end
      count <= count + 2'(push_ok) - 2'(pop_ok);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, imem req/ack, 2-entry buffer, redirect/drain.
// Define INST_FETCH_MISALIGN_CHK_EN to flag and halt on misaligned redirects.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = FIFO_ENTRIES
) (
  input  logic         clk,
  input  logic         rst_n,
  inst_fetch_if.master bus
);

  fetch_state_e state;
  fetch_state_e state_n;
  logic [31:0]  pc;
  logic [31:0]  pc_n;
  logic [31:0]  drain_addr;
  logic [31:0]  drain_addr_n;
  logic [31:0]  fetch_addr;
  logic         fetch_req;
  logic         has_space;
  logic         halted;
  logic         push;
  logic         pop;
  logic         flush;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_entry;

`ifdef INST_FETCH_MISALIGN_CHK_EN
  logic misalign_err;
  logic misalign_err_n;

  assign halted                 = misalign_err;
  assign bus.fetch_misalign_err = misalign_err;
`else
  assign halted = 1'b0;
`endif

  assign has_space  = 32'(count) < FIFO_DEPTH;
  assign push_entry = '{pc: pc, word: bus.imem_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH_ST_FETCH;
      pc         <= RESET_PC;
      drain_addr <= RESET_PC;
`ifdef INST_FETCH_MISALIGN_CHK_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      drain_addr <= drain_addr_n;
`ifdef INST_FETCH_MISALIGN_CHK_EN
      misalign_err <= misalign_err_n;
`endif
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    drain_addr_n = drain_addr;
    push         = 1'b0;
    flush        = 1'b0;
    fetch_req    = 1'b0;
    fetch_addr   = pc;
`ifdef INST_FETCH_MISALIGN_CHK_EN
    misalign_err_n = misalign_err;
`endif

    // The request is gated by rst_n so it is low for the whole reset.
    unique case (state)
      FETCH_ST_FETCH: begin
        fetch_req  = rst_n && has_space && !halted;
        fetch_addr = pc;
      end
      FETCH_ST_DRAIN: begin
        fetch_req  = rst_n;
        fetch_addr = drain_addr;
      end
      default: ;
    endcase

    pop = (count != 2'd0) && bus.inst_ready && !bus.redirect_valid;

    if (bus.redirect_valid) begin
      flush = 1'b1;
      pc_n  = word_align(bus.redirect_pc);
`ifdef INST_FETCH_MISALIGN_CHK_EN
      misalign_err_n = |bus.redirect_pc[1:0];
`endif
      // An outstanding request must still complete; its address is kept
      // and its data thrown away in DRAIN.
      if (state == FETCH_ST_FETCH) begin
        if (fetch_req && !bus.imem_ack) begin
          state_n      = FETCH_ST_DRAIN;
          drain_addr_n = pc;
        end
      end else if (bus.imem_ack) begin
        state_n = FETCH_ST_FETCH;
      end
    end else if (fetch_req && bus.imem_ack) begin
      if (state == FETCH_ST_FETCH) begin
        push = 1'b1;
        pc_n = pc + 32'd4;
      end else begin
        state_n = FETCH_ST_FETCH;
      end
    end
  end

  inst_fetch_fifo #(
    .WIDTH($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign bus.imem_req   = fetch_req;
  assign bus.imem_addr  = fetch_addr;
  assign bus.inst_valid = (count != 2'd0);
  assign bus.inst_word  = head.word;
  assign bus.inst_pc    = head.pc;
  assign bus.inst_op    = head.word[OP_MSB:OP_LSB];
  assign bus.inst_func  = head.word[FUNC_MSB:FUNC_LSB];

endmodule
